// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and widths for the clk_div_ctrl clock-divider controller.
// Optional build macro CLK_DIV_CTRL_CNT_EN uses UPD_CNT_W and sat_inc().
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int DIV_W_DEFAULT = 8;
    localparam int UPD_CNT_W     = 8;

    localparam logic [UPD_CNT_W-1:0] UPD_CNT_MAX = '1;

    // Saturating increment for the update counter.
    function automatic logic [UPD_CNT_W-1:0] sat_inc(input logic [UPD_CNT_W-1:0] v);
        return (v == UPD_CNT_MAX) ? v : v + UPD_CNT_W'(1);
    endfunction

endpackage

// File: rtl/clk_div_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; grant is one-hot or zero, and the
// priority pointer moves to the non-winning side whenever a grant is taken.
module rr_arb2
    import clk_div_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic r_ptr;  // 0 favours requester 0 on contention

    always_comb begin
        // NOTE: gnt gets a default before the case so every path assigns it and no latch is inferred.
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (advance) begin
            r_ptr <= ~gnt[1];
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable integer clock divider with round-robin shared config port and
// boundary-aligned ratio updates. Define CLK_DIV_CTRL_CNT_EN to add update_cnt.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     req_valid,
    input  logic [2*W-1:0] req_div,
    output logic [1:0]     req_ready,
    output logic [W-1:0]   cur_div,
    output logic           tick,
    output logic           div_out,
    output logic           running,
    output logic           update_done
`ifdef CLK_DIV_CTRL_CNT_EN
    ,output logic [UPD_CNT_W-1:0] update_cnt
`endif
);

    state_t       r_state;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_cur_div;
    logic [W-1:0] r_pend_div;
    logic         r_div_out;
    logic         r_update_done;

    logic [1:0]   w_gnt;
    logic [1:0]   w_ready;
    logic         w_accept;
    logic [W-1:0] w_acc_div;
    logic [W-1:0] w_last;
    logic         w_running;
    logic         w_tick;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (w_accept),
        .gnt     (w_gnt)
    );

    // A held update blocks new requests until it has been applied.
    assign w_ready   = (r_state == PEND) ? 2'b00 : w_gnt;
    assign w_accept  = |(req_valid & w_ready);
    assign w_acc_div = w_gnt[1] ? req_div[2*W-1:W] : req_div[W-1:0];

    assign w_running = (r_state != IDLE);
    assign w_last    = r_cur_div - W'(1);
    assign w_tick    = w_running && (r_cnt == w_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_cur_div     <= '0;
            r_pend_div    <= '0;
            r_div_out     <= 1'b0;
            r_update_done <= 1'b0;
        end else begin
            r_update_done <= 1'b0;

            if (w_running) begin
                if (w_tick) begin
                    r_cnt     <= '0;
                    r_div_out <= ~r_div_out;
                end else begin
                    r_cnt <= r_cnt + W'(1);
                end
            end

            // NOTE: a later non-blocking assignment to the same flop in this block overrides the counting default above.
            case (r_state)
                IDLE: begin
                    if (w_accept && (w_acc_div != '0)) begin
                        r_cur_div     <= w_acc_div;
                        r_cnt         <= '0;
                        r_div_out     <= 1'b0;
                        r_state       <= RUN;
                        r_update_done <= 1'b1;
                    end
                end
                RUN: begin
                    // A tick in the accept cycle still closes with the old ratio.
                    if (w_accept) begin
                        r_pend_div <= w_acc_div;
                        r_state    <= PEND;
                    end
                end
                PEND: begin
                    if (w_tick) begin
                        r_update_done <= 1'b1;
                        if (r_pend_div != '0) begin
                            r_cur_div <= r_pend_div;
                            r_state   <= RUN;
                        end else begin
                            r_cur_div <= '0;
                            r_div_out <= 1'b0;
                            r_state   <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CLK_DIV_CTRL_CNT_EN
    logic [UPD_CNT_W-1:0] r_update_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_update_cnt <= '0;
        end else if (r_update_done) begin
            r_update_cnt <= sat_inc(r_update_cnt);
        end
    end

    assign update_cnt = r_update_cnt;
`endif

    assign req_ready   = w_ready;
    assign cur_div     = r_cur_div;
    assign tick        = w_tick;
    assign div_out     = r_div_out;
    assign running     = w_running;
    assign update_done = r_update_done;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a cycle-time reference model queues expected
// accepts, ticks and updates; a monitor compares them as the DUT presents them.
module tb_clk_div_ctrl;
    import clk_div_ctrl_pkg::*;

    localparam int W = DIV_W_DEFAULT;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req_valid;
    logic [2*W-1:0] req_div;
    logic [1:0]     req_ready;
    logic [W-1:0]   cur_div;
    logic           tick;
    logic           div_out;
    logic           running;
    logic           update_done;
`ifdef CLK_DIV_CTRL_CNT_EN
    logic [UPD_CNT_W-1:0] update_cnt;
`endif

    clk_div_ctrl #(.W(W)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_div     (req_div),
        .req_ready   (req_ready),
        .cur_div     (cur_div),
        .tick        (tick),
        .div_out     (div_out),
        .running     (running),
        .update_done (update_done)
`ifdef CLK_DIV_CTRL_CNT_EN
        ,.update_cnt (update_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [W-1:0] div;
        logic         out;
        logic         run;
    } ev_t;

    typedef struct {
        int         cyc;
        logic [1:0] mask;
    } acc_t;

    ev_t  tick_q[$];
    ev_t  upd_q[$];
    acc_t acc_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [1:0] dut_acc = 2'b00;

    // Reference model: ratio in force, absolute cycle of next boundary, output level.
    int   m_div;
    int   m_next;
    logic m_out;
    bit   m_has_pend;
    int   m_pend;
    bit   m_ptr;
    int   m_upd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            m_div = 0; m_next = 0; m_out = 1'b0; m_has_pend = 0;
            m_pend = 0; m_ptr = 0; m_upd = 0;
            tick_q.delete(); upd_q.delete(); acc_q.delete();
        end else begin
            int idx;
            int d;
            bit acc;
            bit run;
            bit tk;
            run = (m_div != 0);
            tk  = run && (cyc == m_next);
            acc = 0;
            idx = 0;
            if (!m_has_pend) begin
                if (req_valid == 2'b11) begin acc = 1; idx = m_ptr; end
                else if (req_valid[0])  begin acc = 1; idx = 0; end
                else if (req_valid[1])  begin acc = 1; idx = 1; end
            end
            d = (idx == 1) ? int'(req_div[2*W-1:W]) : int'(req_div[W-1:0]);
            if (acc) begin
                acc_q.push_back(acc_t'{cyc, 2'(2'b01 << idx)});
                m_ptr = (idx == 0);
            end
            if (tk) tick_q.push_back(ev_t'{cyc, W'(m_div), m_out, 1'b1});
            if (!run) begin
                if (acc && d != 0) begin
                    m_div = d; m_next = cyc + d; m_out = 1'b0; m_upd++;
                    upd_q.push_back(ev_t'{cyc + 1, W'(m_div), 1'b0, 1'b1});
                end
            end else begin
                if (tk) begin
                    m_out  = ~m_out;
                    m_next = cyc + m_div;
                    if (m_has_pend) begin
                        m_has_pend = 0;
                        if (m_pend != 0) begin
                            m_div = m_pend; m_next = cyc + m_pend;
                        end else begin
                            m_div = 0; m_out = 1'b0;
                        end
                        m_upd++;
                        upd_q.push_back(ev_t'{cyc + 1, W'(m_div), m_out, m_div != 0});
                    end
                end
                if (acc) begin m_has_pend = 1; m_pend = d; end
            end
        end
    end

    always @(negedge clk) begin
        ev_t        e;
        acc_t       a;
        bit         exp_now;
        logic [1:0] got;
        #1;
        if (reset) begin
            dut_acc = 2'b00;
        end else begin
            got = req_valid & req_ready;
            dut_acc = got;
            exp_now = (acc_q.size() > 0) && (acc_q[0].cyc == cyc);
            if (got != 2'b00 || exp_now) begin
                a = exp_now ? acc_q.pop_front() : acc_t'{cyc, 2'b00};
                check("accept_mask", got, a.mask);
            end
            exp_now = (tick_q.size() > 0) && (tick_q[0].cyc == cyc);
            if (tick || exp_now) begin
                check("tick_present", tick, exp_now);
                if (exp_now) begin
                    e = tick_q.pop_front();
                    if (tick) begin
                        check("tick_div_out", div_out, e.out);
                        check("tick_cur_div", cur_div, e.div);
                    end
                end
            end
            exp_now = (upd_q.size() > 0) && (upd_q[0].cyc == cyc);
            if (update_done || exp_now) begin
                check("update_present", update_done, exp_now);
                if (exp_now) begin
                    e = upd_q.pop_front();
                    if (update_done) begin
                        check("update_cur_div", cur_div, e.div);
                        check("update_div_out", div_out, e.out);
                        check("update_running", running, e.run);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input int idx, input int d);
        bit done = 0;
        req_valid[idx] = 1'b1;
        req_div[idx*W +: W] = W'(d);
        for (int k = 0; k < 700 && !done; k++) begin
            step();
            done = dut_acc[idx];
        end
        if (!done) check("accept_timeout", req_ready[idx], 1'b1);
        req_valid[idx] = 1'b0;
    endtask

    task automatic send2(input int d0, input int d1);
        bit [1:0] done = 2'b00;
        req_valid = 2'b11;
        req_div   = {W'(d1), W'(d0)};
        for (int k = 0; k < 700 && done != 2'b11; k++) begin
            step();
            done = done | dut_acc;
            req_valid = req_valid & ~dut_acc;
        end
        if (done != 2'b11) check("accept2_timeout", done, 2'b11);
        req_valid = 2'b00;
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound && running; k++) step();
        if (running) check("wait_idle_timeout", running, 1'b0);
    endtask

    function automatic logic [W-1:0] rand_div();
        int r;
        r = $urandom_range(0, 99);
        if (r < 12) return '0;
        if (r < 80) return W'($urandom_range(1, 6));
        if (r < 99) return W'($urandom_range(7, 20));
        return '1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        req_valid = 2'b00;
        req_div   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cur_div", cur_div, '0);
        check("rst_tick", tick, 1'b0);
        check("rst_div_out", div_out, 1'b0);
        check("rst_running", running, 1'b0);
        check("rst_update_done", update_done, 1'b0);
        check("rst_req_ready", req_ready, 2'b00);
`ifdef CLK_DIV_CTRL_CNT_EN
        check("rst_update_cnt", update_cnt, '0);
`endif
        step();
        reset = 1'b0;
        idle(2);

        // D=3 from IDLE, then 3->4 update, then 4->2 from requester 1 mid-period
        send(0, 3);
        idle(14);
        send(0, 4);
        idle(6);
        send(1, 2);
        idle(16);
        send(0, 0);
        wait_idle(300);
        idle(2);

        // contention in IDLE, then contention with the pointer on requester 1
        send2(5, 7);
        idle(20);
        send(0, 3);
        idle(12);
        send2(2, 4);
        idle(20);
        send(1, 0);
        wait_idle(300);

        // D=1 then stop
        send(0, 1);
        idle(6);
        send(1, 0);
        wait_idle(300);
        idle(3);

        // maximum ratio
        send(0, 255);
        idle(600);
        send(0, 0);
        wait_idle(600);
        idle(2);

        // asynchronous reset while an update is held
        send(0, 4);
        step();
        send(1, 9);
        req_valid = 2'b11;
        #1;
        check("pend_ready_low", req_ready, 2'b00);
        #1;
        reset = 1'b1;
        #1;
        check("async_cur_div", cur_div, '0);
        check("async_div_out", div_out, 1'b0);
        check("async_running", running, 1'b0);
        check("async_tick", tick, 1'b0);
        check("async_update_done", update_done, 1'b0);
        check("async_ready_ptr0", req_ready, 2'b01);
        req_valid = 2'b00;
        idle(3);
        reset = 1'b0;
        idle(30);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && dut_acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 99) < 20) begin
                    req_valid[i] = 1'b1;
                    req_div[i*W +: W] = rand_div();
                end
            end
        end
        step();
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && dut_acc[i]) req_valid[i] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i]) send(i, int'(req_div[i*W +: W]));
        end
        send(0, 0);
        wait_idle(600);
        idle(2);

        // long run of updates to drive the update counter into saturation
        send(0, 1);
        for (int k = 0; k < 260; k++) send(k % 2, 1 + (k % 3));
        idle(10);
`ifdef CLK_DIV_CTRL_CNT_EN
        check("update_cnt_sat", update_cnt, (m_upd > 255) ? 255 : m_upd);
`endif
        send(1, 0);
        wait_idle(100);
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
